// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side drain path.
package fifo_pkg;

    // Read latency of the upstream synchronous FIFO (rd_en -> rd_data).
    localparam int FIFO_RD_LAT = 1;

    // One presented word, one spare so a capture can land during a handshake,
    // plus one slot per word still in flight from the FIFO.
    localparam int SKID_DEPTH = FIFO_RD_LAT + 2;

    // Default word width, matching the FIFO's data_width.
    localparam int DATA_WIDTH = 7;

    typedef logic [DATA_WIDTH-1:0] word_t;

    // Occupancy spans 0..SKID_DEPTH, pointers span 0..SKID_DEPTH-1.
    typedef logic [$clog2(SKID_DEPTH+1)-1:0] occ_t;
    typedef logic [$clog2(SKID_DEPTH)-1:0]   ptr_t;

    // Advance a circular-buffer pointer, wrapping after the last entry.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(SKID_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular buffer that absorbs words arriving from the FIFO read port
// and presents the oldest one at head_data. occ reports the current fill level.
module fifo_rd_skid #(
    parameter int WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head_data,
    output fifo_pkg::occ_t       occ
);
    import fifo_pkg::*;

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    ptr_t             rd_ptr;
    ptr_t             wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Never pop an empty buffer; a push into a full buffer is only legal
    // when the same cycle also frees the head entry.
    assign pop_ok  = pop && (occ != '0);
    assign push_ok = push && ((occ != occ_t'(SKID_DEPTH)) || pop_ok);

    assign head_data = mem[rd_ptr];

    // Entry storage: written at wr_ptr on each accepted push.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the entries are cleared on reset because the head entry drives
            // an output port directly and must read as zero after reset; a wide
            // RAM without that visibility would be left unreset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            // NOTE: clocked state uses <= so every register in the design sees
            // pre-edge values regardless of block evaluation order.
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push and pop together leave occ unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   occ <= occ + occ_t'(1);
                2'b01:   occ <= occ - occ_t'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the synchronous FIFO's 1-cycle-latency read port into a valid/ready
// stream at full throughput, framing the words into fixed-length packets.
// fifo_rd_en depends only on registered state and fifo_empty, never on m_ready.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int PKT_LEN    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  pkt_cnt
);
    import fifo_pkg::*;

    // A one-word packet still needs a 1-bit index so the compare below is legal.
    localparam int                   IDX_WIDTH = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(PKT_LEN - 1);

    logic                  inflight;
    occ_t                  occ;
    logic [$bits(occ_t):0] committed;
    logic [DATA_WIDTH-1:0] head_data;
    logic [IDX_WIDTH-1:0]  word_idx;
    logic                  handshake;

    // Words already buffered plus the one still crossing the FIFO read latency;
    // popping only while this is below the depth means a capture always has room.
    assign committed  = {1'b0, occ} + ($bits(occ_t) + 1)'(inflight);
    assign fifo_rd_en = !rst && !fifo_empty && (committed < ($bits(occ_t) + 1)'(SKID_DEPTH));

    assign m_valid   = (occ != '0);
    assign m_data    = head_data;
    assign m_last    = m_valid && (word_idx == LAST_IDX);
    assign handshake = m_valid && m_ready;

    // Remember last cycle's pop so its data is captured when it appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd_en;
        end
    end

    // Packet framing: position within the packet and completed-packet count.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_idx <= '0;
            pkt_cnt  <= '0;
        end else if (handshake) begin
            if (word_idx == LAST_IDX) begin
                word_idx <= '0;
                pkt_cnt  <= pkt_cnt + CNT_WIDTH'(1);
            end else begin
                word_idx <= word_idx + IDX_WIDTH'(1);
            end
        end
    end

    fifo_rd_skid #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (handshake),
        .head_data (head_data),
        .occ       (occ)
    );

endmodule
